imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory as N-bit words
// Ports: clk; reset (sync, active high); start (begin a session);
//   in_data/in_valid/in_ready (byte stream, transfer when valid and ready);
//   we/waddr/wdata (instruction-memory write port, one cycle after a word completes);
//   cpu_hold (processor held in reset during a session); busy, done, error (session status).
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module imem_loader #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         we,
   output logic [7:0]   waddr,
   output logic [N-1:0] wdata,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic         error
);
   localparam int B  = N / 8;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam logic [BW-1:0] BL = BW'(B - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, FIN, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, FIN} state_t;
`endif
   state_t          state, next;
   logic [BW-1:0]   bidx;
   logic [7:0]      widx, wlast;
   logic [N-1:0]    word, asm_word;
   logic            fin_pend, xfer, last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]      csum;
   logic            err;
   assign error = err;
`else
   assign error = 1'b0;
`endif
   // fin_pend marks the cycle in which the final word is being written: the FSM stays in
   // DATA (so we is only ever high in DATA) but stops accepting bytes until it leaves.
   always_comb begin
      next     = state;
      in_ready = 1'b0;
      case (state)
         IDLE: next = start ? LEN : IDLE;
         LEN: begin
            in_ready = 1'b1;
            next     = in_valid ? DATA : LEN;
         end
         DATA: begin
            in_ready = !fin_pend;
`ifdef IMEM_LOADER_CHECKSUM_EN
            next     = fin_pend ? CSUM : DATA;
`else
            next     = fin_pend ? FIN : DATA;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            next     = !in_valid ? CSUM : (in_data == csum) ? FIN : ERR;
         end
         ERR: next = start ? IDLE : ERR;
`endif
         FIN: next = IDLE;
         default: next = IDLE;
      endcase
      xfer      = in_valid && in_ready;
      last_byte = xfer && state == DATA && bidx == BL;
      asm_word  = word;
      for (int k = 0; k < B; k++) asm_word[8*k +: 8] = (bidx == BW'(k)) ? in_data : word[8*k +: 8];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cpu_hold <= 1'b1;
         widx     <= '0;
         wlast    <= '0;
         bidx     <= '0;
         word     <= '0;
         fin_pend <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum     <= '0;
         err      <= 1'b0;
`endif
      end else begin
         state <= next;
         we    <= last_byte;
         if (state == IDLE) cpu_hold <= start;
         if (state == IDLE && start) begin
            busy <= 1'b1;
            done <= 1'b0;
            widx <= '0;
            bidx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= '0;
            err  <= 1'b0;
`endif
         end
         // wlast = W-1; a length byte of 0 wraps to 255, i.e. 256 words
         if (state == LEN && xfer) wlast <= in_data - 8'd1;
         if (state == DATA && xfer) begin
            word <= asm_word;
            bidx <= (bidx == BL) ? '0 : bidx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
         end
         if (last_byte) begin
            waddr    <= widx;
            wdata    <= asm_word;
            widx     <= widx + 8'd1;
            fin_pend <= widx == wlast;
         end
         if (state == DATA && fin_pend) fin_pend <= 1'b0;
         if (state == FIN) begin
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (state == CSUM && xfer && in_data != csum) begin
            busy <= 1'b0;
            err  <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sessions against a write scoreboard for imem_loader
module tb_imem_loader;
   localparam int N = 32;
   localparam int B = N / 8;
   typedef logic [7:0] bq_t[$];
   logic         clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [7:0]   in_data = 8'd0;
   logic         in_ready, we, cpu_hold, busy, done, error;
   logic [7:0]   waddr;
   logic [N-1:0] wdata;
   logic [N+7:0] sb[$];
   int           vecs = 0, errs = 0, cyc = 0, last_we = 0;

   imem_loader #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
      vecs++;
      assert (got === exp_v) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (we === 1'b1) begin
         logic [N+7:0] e;
         last_we = cyc;
         if (sb.size() == 0) chk("spurious_we", 64'(we), 64'd0);
         else begin
            e = sb.pop_front();
            chk("waddr", 64'(waddr), 64'(e[N+7:N]));
            chk("wdata", 64'(wdata), 64'(e[N-1:0]));
         end
      end
   end

   function automatic bq_t rand_stream(input int w);
      bq_t q;
      q.push_back(8'(w));
      for (int i = 0; i < ((w == 0) ? 256 : w) * B; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic push_words(input bq_t s, input int count);
      logic [N-1:0] w;
      for (int i = 0; i < count; i++) begin
         for (int k = 0; k < B; k++) w[8*k +: 8] = s[1 + i*B + k];
         sb.push_back({8'(i), w});
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t == 100) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic session(input bq_t s, input int gapmax, input int poke, input bit model, input bit bad);
      logic [7:0] x = 8'd0;
      int t = 0;
      if (model) push_words(s, (s[0] == 0) ? 256 : int'(s[0]));
      for (int i = 1; i < s.size(); i++) x ^= s[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_at_start", 64'(busy), 64'd1);
      chk("hold_at_start", 64'(cpu_hold), 64'd1);
      chk("done_cleared", 64'(done), 64'd0);
      for (int i = 0; i < s.size(); i++) begin
         if (i == poke) start = 1'b1;
         send(s[i], (gapmax > 0 && i != s.size() - 1) ? int'($urandom_range(gapmax)) : 0);
         start = 1'b0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(bad ? ~x : x, 0);
`endif
      in_valid = 1'b0;
      while (done !== 1'b1 && error !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t == 50) chk("session_end_timeout", 64'(done | error), 64'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("done_latency", 64'(cyc - last_we), 64'd2);
`endif
      chk("done", 64'(done), 64'(!bad));
      chk("error", 64'(error), 64'(bad));
      chk("cpu_hold_end", 64'(cpu_hold), 64'(bad));
      chk("busy_end", 64'(busy), 64'd0);
      chk("writes_pending", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk("done_sticky", 64'(done), 64'(!bad));
   endtask

   initial begin
      bq_t s;
      repeat (2) @(negedge clk);
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      chk("rst_waddr", 64'(waddr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cpu_hold_release", 64'(cpu_hold), 64'd0);
      s = '{8'h02, 8'h36, 8'h0D, 8'h80, 8'hD2, 8'h16, 8'h00, 8'h0B, 8'hF8};
      sb.push_back({8'h00, 32'hD2800D36});
      sb.push_back({8'h01, 32'hF80B0016});
      session(s, 0, -1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sb.push_back({8'h00, 32'hD2800D36});
      sb.push_back({8'h01, 32'hF80B0016});
      session(s, 0, -1, 1'b0, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("err_exit_hold", 64'(cpu_hold), 64'd0);
`endif
      session(rand_stream(0), 0, -1, 1'b1, 1'b0);
      session(rand_stream(5), 3, -1, 1'b1, 1'b0);
      session(rand_stream(3), 0, 6, 1'b1, 1'b0);
      s = rand_stream(6);
      push_words(s, 3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 1 + 3*B + 2; i++) send(s[i], 0);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_we", 64'(we), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_error", 64'(error), 64'd0);
      chk("abort_cpu_hold", 64'(cpu_hold), 64'd1);
      chk("abort_waddr", 64'(waddr), 64'd0);
      chk("abort_wdata", 64'(wdata), 64'd0);
      chk("abort_pending", 64'(sb.size()), 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_hold_release", 64'(cpu_hold), 64'd0);
      chk("abort_idle_ready", 64'(in_ready), 64'd0);
      session(rand_stream(2), 1, -1, 1'b1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
